// File: rtl/regfile_seq.sv
// Command sequencer that drives the 8x16 register file port. It expands WRIMM, READ,
// COPY and SWAP commands into per-cycle read and write strobes.
//   state | meaning
//   IDLE  | cmd_ready high; the command is latched on cmd_valid
//   RD_A  | present ra on readnum; capture Ra into tmp_a
//   RD_B  | present rb on readnum; capture Rb into tmp_b
//   WR_A  | write imm (WRIMM) or tmp_b (SWAP) into Ra
//   WR_B  | write tmp_a into Rb
//   DONE  | one-cycle done pulse, result valid
module regfile_seq #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_ra,
  input  logic [ADDR_W-1:0] cmd_rb,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] rf_writenum,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_readnum,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [DATA_W-1:0] rf_data_out,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR_A = 3'd3,
    WR_B = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [1:0] OP_WRIMM = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_SWAP  = 2'b11;

  state_t            state, state_nxt;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] ra_q, rb_q;
  logic [DATA_W-1:0] imm_q, tmp_a, tmp_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      imm_q  <= '0;
      tmp_a  <= '0;
      tmp_b  <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cmd_valid) begin
        op_q  <= cmd_op;
        ra_q  <= cmd_ra;
        rb_q  <= cmd_rb;
        imm_q <= cmd_imm;
      end
      if (state == RD_A) tmp_a <= rf_data_out;
      if (state == RD_B) tmp_b <= rf_data_out;
      // READ goes RD_A->DONE directly, so its result comes straight off the port.
      if (state_nxt == DONE) begin
        if (op_q == OP_WRIMM)   result <= imm_q;
        else if (state == RD_A) result <= rf_data_out;
        else                    result <= tmp_a;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_valid) state_nxt = (cmd_op == OP_WRIMM) ? WR_A : RD_A;
      RD_A: begin
        case (op_q)
          OP_SWAP: state_nxt = RD_B;
          OP_COPY: state_nxt = WR_B;
          default: state_nxt = DONE;
        endcase
      end
      RD_B:    state_nxt = WR_A;
      WR_A:    state_nxt = (op_q == OP_SWAP) ? WR_B : DONE;
      WR_B:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = (state == IDLE);
    done        = (state == DONE);
    rf_write    = 1'b0;
    rf_writenum = '0;
    rf_data_in  = '0;
    rf_readnum  = ra_q;
    case (state)
      RD_B: rf_readnum = rb_q;
      WR_A: begin
        rf_write    = 1'b1;
        rf_writenum = ra_q;
        rf_data_in  = (op_q == OP_SWAP) ? tmp_b : imm_q;
      end
      WR_B: begin
        rf_write    = 1'b1;
        rf_writenum = rb_q;
        rf_data_in  = tmp_a;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_seq.sv
// Self-checking bench for regfile_seq: a behavioural register file on the port,
// directed scenarios plus random commands checked against an array-based model.
module tb_regfile_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_ra, cmd_rb;
  logic [15:0] cmd_imm;
  logic [2:0]  rf_writenum, rf_readnum;
  logic        rf_write;
  logic [15:0] rf_data_in, rf_data_out;
  logic        done;
  logic [15:0] result;

  int vectors = 0;
  int miscompares = 0;
  int wr_count = 0;

  logic [15:0] rf_mem [8];
  logic [15:0] model_mem [8];

  regfile_seq #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm),
    .rf_writenum(rf_writenum), .rf_write(rf_write), .rf_readnum(rf_readnum),
    .rf_data_in(rf_data_in), .rf_data_out(rf_data_out), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_write === 1'b1) begin
      rf_mem[rf_writenum] <= rf_data_in;
      wr_count <= wr_count + 1;
    end
  end

  assign rf_data_out = rf_mem[rf_readnum];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag);
    for (int r = 0; r < 8; r++) check($sformatf("%s_r%0d", tag, r), rf_mem[r], model_mem[r]);
  endtask

  // Issue one command, let the model predict it, then check latency, result and writes.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] ra, input logic [2:0] rb,
                         input logic [15:0] imm, input bit hold);
    logic [15:0] a, b, exp_res;
    int exp_lat, exp_wr, lat, wr0;
    a = model_mem[ra];
    b = model_mem[rb];
    case (op)
      2'b00: begin exp_res = imm; exp_lat = 2; exp_wr = 1; model_mem[ra] = imm; end
      2'b01: begin exp_res = a;   exp_lat = 2; exp_wr = 0; end
      2'b10: begin exp_res = a;   exp_lat = 3; exp_wr = 1; model_mem[rb] = a; end
      default: begin
        exp_res = a; exp_lat = 5; exp_wr = 2;
        model_mem[ra] = b;
        model_mem[rb] = a;
      end
    endcase
    @(negedge clk);
    check("ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
    wr0 = wr_count;
    lat = 0;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (hold) begin
          cmd_op = ~op; cmd_ra = rb ^ 3'd5; cmd_rb = ra ^ 3'd6; cmd_imm = ~imm;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      if (hold) check("ready_busy", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    check("latency", lat, exp_lat);
    check("result", result, exp_res);
    check("write_pulses", wr_count - wr0, exp_wr);
    check_mem("regs");
  endtask

  initial begin
    logic [15:0] old1;
    int wr0;
    for (int r = 0; r < 8; r++) begin
      rf_mem[r] = '0;
      model_mem[r] = '0;
    end
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_imm = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_write", rf_write, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    reset = 1'b0;

    // WRIMM then READ of R3
    run_cmd(2'b00, 3'd3, 3'd0, 16'h1234, 1'b0);
    run_cmd(2'b01, 3'd3, 3'd0, 16'h0000, 1'b0);
    check("readnum_holds_ra", rf_readnum, 3);

    // Reset while idle with non-zero state captured
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("idle_rst_ready", cmd_ready, 1);
    check("idle_rst_write", rf_write, 0);
    check("idle_rst_writenum", rf_writenum, 0);
    check("idle_rst_readnum", rf_readnum, 0);
    check("idle_rst_data_in", rf_data_in, 0);
    check("idle_rst_done", done, 0);
    check("idle_rst_result", result, 0);
    @(negedge clk);
    reset = 1'b0;

    // COPY R3 -> R5, then READ R5
    run_cmd(2'b10, 3'd3, 3'd5, 16'h0000, 1'b0);
    run_cmd(2'b01, 3'd5, 3'd0, 16'h0000, 1'b0);
    check("copy_r5", result, 16'h1234);
    check("copy_r3_kept", rf_mem[3], 16'h1234);

    // SWAP R1/R2 with cmd_valid held and a different command presented
    run_cmd(2'b00, 3'd1, 3'd0, 16'hAAAA, 1'b0);
    run_cmd(2'b00, 3'd2, 3'd0, 16'h5555, 1'b0);
    run_cmd(2'b11, 3'd1, 3'd2, 16'h0000, 1'b1);
    check("swap_r1", rf_mem[1], 16'h5555);
    check("swap_r2", rf_mem[2], 16'hAAAA);

    // ra == rb corner cases
    run_cmd(2'b10, 3'd4, 3'd4, 16'h0000, 1'b0);
    run_cmd(2'b11, 3'd2, 3'd2, 16'h0000, 1'b0);

    // SWAP R2,R1 reset in WR_B: R2 already took old R1, R1 is never written
    @(negedge clk);
    old1 = model_mem[1];
    cmd_valid = 1'b1;
    cmd_op = 2'b11; cmd_ra = 3'd2; cmd_rb = 3'd1; cmd_imm = 16'hFFFF;
    wr0 = wr_count;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = 1'b0;
    end
    check("wrb_write", rf_write, 1);
    check("wrb_writenum", rf_writenum, 1);
    reset = 1'b1;
    #1;
    check("midrst_write", rf_write, 0);
    check("midrst_ready", cmd_ready, 1);
    check("midrst_done", done, 0);
    check("midrst_writenum", rf_writenum, 0);
    @(negedge clk);
    reset = 1'b0;
    model_mem[2] = old1;
    check("midrst_pulses", wr_count - wr0, 1);
    check("midrst_r1", rf_mem[1], 16'h5555);
    check("midrst_r2", rf_mem[2], 16'h5555);
    check_mem("midrst");

    // Random commands against the model
    for (int i = 0; i < 30; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              16'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
